// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780-compatible responder.
//   - Instruction opcode masks and the instruction-class decoder
//   - Default busy durations in clocks at 50 MHz
//   - DDRAM line base and last addresses, blank character
//   - Responder FSM state enum
//   - Address-counter step helper with HD44780 two-line wrap
package lcd_pkg;

    localparam int unsigned BUSY_SHORT_DEF = 2000;   // 40 us
    localparam int unsigned BUSY_LONG_DEF  = 76500;  // 1.53 ms

    localparam logic [7:0] OP_SET_DDRAM = 8'h80;
    localparam logic [7:0] OP_SET_CGRAM = 8'h40;
    localparam logic [7:0] OP_FUNCTION  = 8'h20;
    localparam logic [7:0] OP_SHIFT     = 8'h10;
    localparam logic [7:0] OP_DISPLAY   = 8'h08;
    localparam logic [7:0] OP_ENTRY     = 8'h04;
    localparam logic [7:0] OP_HOME      = 8'h02;
    localparam logic [7:0] OP_CLEAR     = 8'h01;

    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam logic [6:0] LINE0_LAST = 7'h27;
    localparam logic [6:0] LINE1_LAST = 7'h67;

    localparam logic [7:0] CHAR_BLANK = 8'h20;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_IDLE,
        ST_WAIT
    } lcd_state_e;

    typedef enum logic [3:0] {
        INS_NOP,
        INS_CLEAR,
        INS_HOME,
        INS_ENTRY,
        INS_DISPLAY,
        INS_SHIFT,
        INS_FUNCTION,
        INS_CGRAM,
        INS_DDRAM
    } lcd_instr_e;

    // Highest set bit selects the instruction class.
    function automatic lcd_instr_e decode_instr(input logic [7:0] d);
        lcd_instr_e r;
        if      ((d & OP_SET_DDRAM) != '0) r = INS_DDRAM;
        else if ((d & OP_SET_CGRAM) != '0) r = INS_CGRAM;
        else if ((d & OP_FUNCTION)  != '0) r = INS_FUNCTION;
        else if ((d & OP_SHIFT)     != '0) r = INS_SHIFT;
        else if ((d & OP_DISPLAY)   != '0) r = INS_DISPLAY;
        else if ((d & OP_ENTRY)     != '0) r = INS_ENTRY;
        else if ((d & OP_HOME)      != '0) r = INS_HOME;
        else if ((d & OP_CLEAR)     != '0) r = INS_CLEAR;
        else                               r = INS_NOP;
        return r;
    endfunction

    // Line 0 runs 0x00..0x27, line 1 runs 0x40..0x67; each end wraps to the other line.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if      (ac == LINE0_LAST) r = LINE1_BASE;
            else if (ac == LINE1_LAST) r = LINE0_BASE;
            else                       r = ac + 7'd1;
        end else begin
            if      (ac == LINE0_BASE) r = LINE1_LAST;
            else if (ac == LINE1_BASE) r = LINE0_LAST;
            else                       r = ac - 7'd1;
        end
        return r;
    endfunction

    // Only columns 0..15 of each line are backed by storage.
    function automatic logic ac_visible(input logic [6:0] ac);
        return (ac[5:4] == 2'b00);
    endfunction

endpackage

// File: rtl/lcd_hd44780_responder_if.sv
// lcd_hd44780_responder_if: 8-bit HD44780 character-LCD bus.
//   lcd_rs       register select (0 instruction, 1 data)
//   lcd_rw       0 write, 1 read
//   lcd_e        enable strobe
//   lcd_data_in  bus from initiator
//   lcd_data_out bus to initiator during reads
//   lcd_data_oe  drive enable for lcd_data_out
// master: the LCD driver side; slave: the display side.
interface lcd_hd44780_responder_if;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data_in;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;

    modport master (
        output lcd_rs, lcd_rw, lcd_e, lcd_data_in,
        input  lcd_data_out, lcd_data_oe
    );

    modport slave (
        input  lcd_rs, lcd_rw, lcd_e, lcd_data_in,
        output lcd_data_out, lcd_data_oe
    );
endinterface

// File: rtl/lcd_bus_sync.sv
// lcd_bus_sync: input synchronizer and enable-strobe edge detector.
//   clk, reset       system clock, asynchronous active-high reset
//   lcd_rs/rw/e/data_in  raw bus inputs
//   rs, rw, e, data  synchronized bus values
//   e_fall, e_rise   one-clock pulses on synchronized e edges
// Parameter SYNC_STAGES: flip-flops on each input (>= 1).
module lcd_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [7:0] lcd_data_in,
    output logic       rs,
    output logic       rw,
    output logic       e,
    output logic [7:0] data,
    output logic       e_fall,
    output logic       e_rise
);

    // Packed as {rs, rw, e, data[7:0]}.
    logic [10:0] stage [SYNC_STAGES];
    logic [10:0] last;
    logic        e_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
            e_prev <= 1'b0;
        end else begin
            stage[0] <= {lcd_rs, lcd_rw, lcd_e, lcd_data_in};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
            e_prev <= stage[SYNC_STAGES-1][8];
        end
    end

    assign last              = stage[SYNC_STAGES-1];
    assign {rs, rw, e, data} = last;
    assign e_fall            = e_prev & ~e;
    assign e_rise            = e & ~e_prev;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// lcd_hd44780_responder: display end of an 8-bit HD44780 character-LCD bus.
// Decodes instructions, holds a 2x16 DDRAM, models the busy flag and answers
// busy-flag and data reads.
//   clk, reset   50 MHz clock, asynchronous active-high reset
//   bus          lcd_hd44780_responder_if.slave (rs/rw/e/data in, data out/oe)
//   busy         busy flag (FILL or WAIT)
//   disp_on      display-control D bit
//   cursor_addr  DDRAM address counter
//   rd_addr      {line, col} scanner read address
//   rd_char      DDRAM[rd_addr], one clock latency
//   proto_err    sticky protocol error
// Build option LCD_PROTOCOL_CHECK_EN: when defined, proto_err flags write
// strobes dropped while busy and e-high pulses shorter than 12 clocks;
// otherwise proto_err is tied low.
module lcd_hd44780_responder
    import lcd_pkg::*;
#(
    parameter int unsigned BUSY_SHORT  = BUSY_SHORT_DEF,
    parameter int unsigned BUSY_LONG   = BUSY_LONG_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    lcd_hd44780_responder_if.slave   bus,
    output logic                     busy,
    output logic                     disp_on,
    output logic [6:0]               cursor_addr,
    input  logic [4:0]               rd_addr,
    output logic [7:0]               rd_char,
    output logic                     proto_err
);

    localparam int unsigned CNT_MAX = (BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(BUSY_SHORT - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(BUSY_LONG - 1);

    logic       s_rs, s_rw, s_e, e_fall, e_rise;
    logic [7:0] s_data;

    lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .reset      (reset),
        .lcd_rs     (bus.lcd_rs),
        .lcd_rw     (bus.lcd_rw),
        .lcd_e      (bus.lcd_e),
        .lcd_data_in(bus.lcd_data_in),
        .rs         (s_rs),
        .rw         (s_rw),
        .e          (s_e),
        .data       (s_data),
        .e_fall     (e_fall),
        .e_rise     (e_rise)
    );

    lcd_state_e       state;
    logic [4:0]       fill_idx;
    logic             fill_then_wait;
    logic [CNT_W-1:0] wait_cnt;
    logic [6:0]       ac;
    logic             entry_inc;
    logic [1:0]       cursor_blink_unused;

    logic [7:0]       ddram [32];
    logic             wr_strobe, wr_accept, rd_data_fall;
    lcd_instr_e       instr;
    logic             ram_we;
    logic [4:0]       ram_waddr;
    logic [7:0]       ram_wdata;
    logic [7:0]       data_out_q;
    logic             data_oe_q;

    always_comb begin
        wr_strobe    = e_fall && !s_rw;
        wr_accept    = wr_strobe && (state == ST_IDLE);
        rd_data_fall = e_fall && s_rw && s_rs && (state != ST_FILL);
        instr        = decode_instr(s_data);
        ram_we       = 1'b0;
        ram_waddr    = fill_idx;
        ram_wdata    = CHAR_BLANK;
        if (state == ST_FILL) begin
            ram_we = 1'b1;
        end else if (wr_accept && s_rs && ac_visible(ac)) begin
            ram_we    = 1'b1;
            ram_waddr = {ac[6], ac[3:0]};
            ram_wdata = s_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= ST_FILL;
            fill_idx            <= '0;
            fill_then_wait      <= 1'b0;
            wait_cnt            <= '0;
            ac                  <= '0;
            entry_inc           <= 1'b1;
            disp_on             <= 1'b0;
            cursor_blink_unused <= '0;
            busy                <= 1'b1;
        end else begin
            case (state)
                ST_FILL: begin
                    ac       <= '0;
                    fill_idx <= fill_idx + 5'd1;
                    if (fill_idx == 5'd31) begin
                        fill_then_wait <= 1'b0;
                        if (fill_then_wait) begin
                            state    <= ST_WAIT;
                            wait_cnt <= LONG_LOAD;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    // Reads are honoured while busy, including the AC step.
                    if (rd_data_fall) ac <= ac_step(ac, entry_inc);
                    if (wait_cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    if (rd_data_fall) begin
                        ac <= ac_step(ac, entry_inc);
                    end else if (wr_accept) begin
                        state    <= ST_WAIT;
                        busy     <= 1'b1;
                        wait_cnt <= SHORT_LOAD;
                        if (s_rs) begin
                            ac <= ac_step(ac, entry_inc);
                        end else begin
                            case (instr)
                                INS_DDRAM:   ac <= s_data[6:0];
                                INS_SHIFT:   if (!s_data[3]) ac <= ac_step(ac, s_data[2]);
                                INS_DISPLAY: begin
                                    disp_on             <= s_data[2];
                                    cursor_blink_unused <= s_data[1:0];
                                end
                                INS_ENTRY:   entry_inc <= s_data[1];
                                INS_HOME: begin
                                    ac       <= '0;
                                    wait_cnt <= LONG_LOAD;
                                end
                                INS_CLEAR: begin
                                    state          <= ST_FILL;
                                    fill_idx       <= '0;
                                    fill_then_wait <= 1'b1;
                                    entry_inc      <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ddram[ram_waddr] <= ram_wdata;
    end

    // Read-before-write: a same-cycle write to rd_addr shows up next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_char <= CHAR_BLANK;
        else       rd_char <= ddram[rd_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
        end else if (s_e && s_rw) begin
            data_oe_q <= 1'b1;
            if (s_rs) data_out_q <= ac_visible(ac) ? ddram[{ac[6], ac[3:0]}] : CHAR_BLANK;
            else      data_out_q <= {busy, ac};
        end else begin
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
        end
    end

    assign bus.lcd_data_out = data_out_q;
    assign bus.lcd_data_oe  = data_oe_q;
    assign cursor_addr      = ac;

`ifdef LCD_PROTOCOL_CHECK_EN
    localparam int unsigned MIN_E_HIGH = 12;
    logic [3:0] e_high_cnt;

    // e_high_cnt holds the number of clocks synchronized e has been high,
    // saturating, so it is still valid on the falling-edge cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_high_cnt <= '0;
            proto_err  <= 1'b0;
        end else begin
            if (e_rise)                         e_high_cnt <= 4'd1;
            else if (s_e && e_high_cnt != '1)   e_high_cnt <= e_high_cnt + 4'd1;
            if ((wr_strobe && state != ST_IDLE) ||
                (e_fall && e_high_cnt < 4'(MIN_E_HIGH)))
                proto_err <= 1'b1;
        end
    end
`else
    logic e_rise_unused;
    assign e_rise_unused = e_rise;
    assign proto_err     = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// tb_lcd_hd44780_responder: self-checking bench for lcd_hd44780_responder.
// Busy durations are shortened through parameter overrides to keep the run short.
module tb_lcd_hd44780_responder;

    localparam int unsigned BUSY_SHORT  = 600;
    localparam int unsigned BUSY_LONG   = 3000;
    localparam int unsigned SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy, disp_on, proto_err;
    logic [6:0] cursor_addr;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;

    lcd_hd44780_responder_if bus();

    lcd_hd44780_responder #(
        .BUSY_SHORT (BUSY_SHORT),
        .BUSY_LONG  (BUSY_LONG),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .disp_on    (disp_on),
        .cursor_addr(cursor_addr),
        .rd_addr    (rd_addr),
        .rd_char    (rd_char),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic       long_busy;
        logic [6:0] exp_ac;
        logic       exp_disp;
    } vec_t;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] exp;
    } scan_item_t;

    vec_t       vecs[$];
    scan_item_t scan_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] exp_scr [32];
    logic       exp_pe;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lcd_write(input logic rs, input logic [7:0] d);
        @(negedge clk);
        bus.lcd_rs      = rs;
        bus.lcd_rw      = 1'b0;
        bus.lcd_data_in = d;
        tick(2);
        bus.lcd_e = 1'b1;
        tick(14);
        bus.lcd_e = 1'b0;
        tick(4);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < int'(BUSY_LONG) + 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 0);
    endtask

    task automatic lcd_read(input string name, input logic rs, input logic [7:0] exp);
        logic [7:0] e;
        @(negedge clk);
        bus.lcd_rs = rs;
        bus.lcd_rw = 1'b1;
        tick(2);
        bus.lcd_e = 1'b1;
        rd_q.push_back(exp);
        tick(10);
        e = rd_q.pop_front();
        chk({name, "_oe"}, bus.lcd_data_oe, 1);
        chk(name, bus.lcd_data_out, e);
        tick(4);
        bus.lcd_e = 1'b0;
        tick(5);
        chk({name, "_oe_off"}, bus.lcd_data_oe, 0);
        bus.lcd_rw = 1'b0;
    endtask

    task automatic scan_all(input string name);
        scan_item_t it;
        for (int i = 0; i <= 32; i++) begin
            @(negedge clk);
            if (scan_q.size() != 0) begin
                it = scan_q.pop_front();
                chk($sformatf("%s[%0d]", name, it.addr), rd_char, it.exp);
            end
            if (i < 32) begin
                rd_addr = 5'(i);
                it.addr = 5'(i);
                it.exp  = exp_scr[i];
                scan_q.push_back(it);
            end
        end
    endtask

    task automatic add_vec(input logic rs, input logic [7:0] d, input logic lb,
                           input logic [6:0] ac, input logic dsp);
        vec_t v;
        v.rs = rs; v.data = d; v.long_busy = lb; v.exp_ac = ac; v.exp_disp = dsp;
        vecs.push_back(v);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        logic [79:0]  s1;
        logic [127:0] s2;
        vec_t         v;
        s1 = "GAME START";
        s2 = "P1:012  P2:345  ";
`ifdef LCD_PROTOCOL_CHECK_EN
        exp_pe = 1'b1;
`else
        exp_pe = 1'b0;
`endif

        // Vector table: init sequence, line 1 text, line 2 text plus overflow.
        add_vec(0, 8'h38, 0, 7'h00, 0);
        add_vec(0, 8'h0C, 0, 7'h00, 1);
        add_vec(0, 8'h01, 1, 7'h00, 1);
        add_vec(0, 8'h06, 0, 7'h00, 1);
        add_vec(0, 8'h80, 0, 7'h00, 1);
        for (int i = 0; i < 10; i++) add_vec(1, s1[8*(9-i) +: 8], 0, 7'(i + 1), 1);
        add_vec(0, 8'hC0, 0, 7'h40, 1);
        for (int i = 0; i < 16; i++) add_vec(1, s2[8*(15-i) +: 8], 0, 7'(7'h41 + i), 1);
        add_vec(1, 8'h21, 0, 7'h51, 1);

        bus.lcd_rs = 0; bus.lcd_rw = 0; bus.lcd_e = 0; bus.lcd_data_in = '0;
        rd_addr = '0;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) exp_scr[i] = 8'h20;
        tick(3);
        chk("rst_data_out", bus.lcd_data_out, 0);
        chk("rst_data_oe", bus.lcd_data_oe, 0);
        chk("rst_busy", busy, 1);
        chk("rst_disp_on", disp_on, 0);
        chk("rst_cursor", cursor_addr, 0);
        chk("rst_rd_char", rd_char, 8'h20);
        chk("rst_proto_err", proto_err, 0);
        @(negedge clk);
        reset = 1'b0;
        tick(40);
        chk("fill_done_busy", busy, 0);
        scan_all("fill");

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            lcd_write(v.rs, v.data);
            if (v.long_busy) begin
                tick(BUSY_SHORT + 100);
                chk("clear_busy_long", busy, 1);
            end
            wait_ready($sformatf("ready_v%0d", k));
            chk($sformatf("ac_v%0d", k), cursor_addr, v.exp_ac);
            chk($sformatf("disp_v%0d", k), disp_on, v.exp_disp);
        end
        for (int i = 0; i < 10; i++) exp_scr[i] = s1[8*(9-i) +: 8];
        for (int i = 0; i < 16; i++) exp_scr[16+i] = s2[8*(15-i) +: 8];
        scan_all("text");

        // Data read at AC=0 returns 'G' and steps AC.
        lcd_write(0, 8'h80);
        wait_ready("ready_home_ac");
        lcd_read("data_read", 1, 8'h47);
        chk("ac_after_read", cursor_addr, 7'h01);

        // Data write about 500 clocks into a busy period is dropped.
        lcd_write(0, 8'h85);
        tick(480);
        lcd_write(1, 8'h5A);
        wait_ready("ready_busy_wr");
        chk("ac_busy_wr", cursor_addr, 7'h05);
        chk("proto_err_busy_wr", proto_err, exp_pe);
        scan_all("busy_wr");

        // Busy-flag read right after setting AC=0x0F.
        lcd_write(0, 8'h8F);
        lcd_read("bf_read", 0, 8'h8F);
        wait_ready("ready_8f");
        chk("ac_8f", cursor_addr, 7'h0F);
        lcd_write(1, 8'h51);
        wait_ready("ready_q");
        chk("ac_wrap_10", cursor_addr, 7'h10);
        lcd_write(1, 8'h52);
        wait_ready("ready_r");
        chk("ac_wrap_11", cursor_addr, 7'h11);
        exp_scr[15] = 8'h51;
        scan_all("col15");

        // Reset in the middle of a strobe.
        @(negedge clk);
        bus.lcd_rs = 1'b1;
        bus.lcd_data_in = 8'h58;
        tick(2);
        bus.lcd_e = 1'b1;
        tick(5);
        reset = 1'b1;
        tick(2);
        chk("midrst_busy", busy, 1);
        chk("midrst_cursor", cursor_addr, 0);
        chk("midrst_disp_on", disp_on, 0);
        chk("midrst_proto_err", proto_err, 0);
        chk("midrst_oe", bus.lcd_data_oe, 0);
        bus.lcd_e = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(40);
        chk("midrst_fill_busy", busy, 0);
        for (int i = 0; i < 32; i++) exp_scr[i] = 8'h20;
        scan_all("refill");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
